// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared CPU constants for the fetch stage
// Opcodes, branch-select codes, instruction field positions and fetch FSM states.
package instr_fetch_unit_pkg;

  localparam logic [7:0] OP_LOADI = 8'd0;
  localparam logic [7:0] OP_LOAD  = 8'd1;
  localparam logic [7:0] OP_STORE = 8'd2;
  localparam logic [7:0] OP_ADD   = 8'd3;
  localparam logic [7:0] OP_SUB   = 8'd4;
  localparam logic [7:0] OP_AND   = 8'd5;
  localparam logic [7:0] OP_OR    = 8'd6;
  localparam logic [7:0] OP_XOR   = 8'd7;
  localparam logic [7:0] OP_SHL   = 8'd8;
  localparam logic [7:0] OP_MULT  = 8'd9;

  typedef enum logic [1:0] {
    BSEL_SEQ  = 2'b00,
    BSEL_JUMP = 2'b01,
    BSEL_BEQ  = 2'b10,
    BSEL_BNE  = 2'b11
  } bsel_e;

  localparam int OPC_LSB = 24;
  localparam int RD_LSB  = 16;
  localparam int RS1_LSB = 8;
  localparam int RS2_LSB = 0;
  localparam int FIELD_W = 8;

  typedef enum logic {
    FETCH = 1'b0,
    ISSUE = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction memory req/ready fetch interface
// master is the fetch unit, slave is the instruction memory.
interface instr_fetch_unit_if #(
  parameter int PC_WIDTH = 32
);
  logic                req;
  logic [PC_WIDTH-1:0] addr;
  logic                ready;
  logic [31:0]         rdata;

  modport master (output req, addr, input ready, rdata);
  modport slave  (input req, addr, output ready, rdata);
endinterface

// File: rtl/instr_fetch_unit_next_pc.sv
// rtl/instr_fetch_unit_next_pc.sv - combinational next-PC selection
// Word offsets are shifted before adding, so an aligned pc stays aligned.
module next_pc_calc
  import instr_fetch_unit_pkg::*;
#(
  parameter int PC_WIDTH = 32
) (
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [7:0]          offset,
  input  logic [1:0]          bselect,
  input  logic                alu_zero,
  output logic [PC_WIDTH-1:0] next_pc
);

  logic [PC_WIDTH-1:0] seq;
  logic [PC_WIDTH-1:0] tgt;
  logic [PC_WIDTH-1:0] off_ext;

  assign off_ext = {{(PC_WIDTH-10){offset[7]}}, offset, 2'b00};
  assign seq     = pc + PC_WIDTH'(4);
  assign tgt     = seq + off_ext;

  always_comb begin
    next_pc = seq;
    case (bselect)
      BSEL_JUMP: next_pc = tgt;
      BSEL_BEQ:  next_pc = alu_zero ? tgt : seq;
      BSEL_BNE:  next_pc = alu_zero ? seq : tgt;
      default:   next_pc = seq;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - program counter, instruction fetch and field split
// Holds one instruction in ISSUE until exec_done, then steps the PC and refetches.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  instr_fetch_unit_if.master   imem,
  output logic                 instr_valid,
  output logic [7:0]           opcode,
  output logic [7:0]           rd_or_offset,
  output logic [7:0]           rs1,
  output logic [7:0]           rs2_or_imm,
  input  logic [1:0]           bselect,
  input  logic                 alu_zero,
  input  logic                 exec_done,
  output logic [PC_WIDTH-1:0]  pc,
  output logic [31:0]          retired_count
);

  fetch_state_e        state;
  fetch_state_e        state_nxt;
  logic                capture;
  logic                retire;
  logic [PC_WIDTH-1:0] next_pc;

  // Gated by RESET_N so no request is seen while reset holds the FSM in FETCH.
  assign imem.req  = (state == FETCH) && RESET_N;
  assign imem.addr = pc;

  next_pc_calc #(.PC_WIDTH(PC_WIDTH)) u_next_pc (
    .pc       (pc),
    .offset   (rd_or_offset),
    .bselect  (bselect),
    .alu_zero (alu_zero),
    .next_pc  (next_pc)
  );

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    retire    = 1'b0;
    case (state)
      FETCH: begin
        if (imem.ready) begin
          capture   = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (exec_done) begin
          retire    = 1'b1;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state         <= FETCH;
      pc            <= RESET_PC;
      retired_count <= '0;
      instr_valid   <= 1'b0;
      opcode        <= '0;
      rd_or_offset  <= '0;
      rs1           <= '0;
      rs2_or_imm    <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        opcode       <= imem.rdata[OPC_LSB +: FIELD_W];
        rd_or_offset <= imem.rdata[RD_LSB  +: FIELD_W];
        rs1          <= imem.rdata[RS1_LSB +: FIELD_W];
        rs2_or_imm   <= imem.rdata[RS2_LSB +: FIELD_W];
        instr_valid  <= 1'b1;
      end
      if (retire) begin
        pc            <= next_pc;
        retired_count <= retired_count + 32'd1;
        instr_valid   <= 1'b0;
      end
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream neighbour of the opcode decoder: owns the program counter, fetches 32-bit instructions from instruction memory over a req/ready handshake, and splits each into fields.
- Presents opcode, destination, source-1, source-2/immediate and offset fields, holding them until the datapath signals completion.
- On completion, computes the next PC from the decoder's 2-bit branch select and the ALU zero flag.

Parameters:
- PC_WIDTH, 32, width of PC and instruction-memory address.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  PC_WIDTH  fetch address (equals pc).
- imem_ready  input  1  memory has valid data this cycle.
- imem_rdata  input  32  instruction word.
- instr_valid  output  1  fields below are valid for the current instruction.
- opcode  output  8  instr[31:24], to the decoder.
- rd_or_offset  output  8  instr[23:16]: destination register, or jump/branch offset in words.
- rs1  output  8  instr[15:8].
- rs2_or_imm  output  8  instr[7:0].
- bselect  input  2  from decoder: 00 sequential, 01 jump, 10 branch-if-zero, 11 branch-if-not-zero.
- alu_zero  input  1  ALU zero flag for the current instruction.
- exec_done  input  1  datapath finished the current instruction (one-cycle pulse).
- pc  output  PC_WIDTH  address of the instruction currently held.
- retired_count  output  32  number of completed instructions.

Behaviour:
- Reset, asynchronous on RESET_N low:
  - state=FETCH, pc=RESET_PC, retired_count=0.
  - imem_req=0, instr_valid=0, all instruction fields 0.
  - Any in-flight fetch or issue is abandoned; no partial field update.
- imem_req is combinational: high exactly when state==FETCH and RESET_N is high. imem_addr=pc at all times.
- FETCH:
  - Hold imem_req high until imem_ready.
  - On a cycle with imem_req & imem_ready: register imem_rdata into the field outputs, set instr_valid=1 and go to ISSUE on that edge.
  - Minimum fetch latency: 1 cycle, i.e. fields are visible the cycle after ready.
  - imem_ready while not requesting is ignored.
- ISSUE:
  - instr_valid=1 and fields stable until exec_done.
  - exec_done is sampled only in ISSUE; elsewhere it is ignored.
- On exec_done in ISSUE:
  - pc <= next_pc, retired_count <= retired_count+1 (wraps at 2^32), instr_valid <= 0, state <= FETCH.
  - The refetch request is asserted the following cycle.
- Next-PC rules:
  - seq = pc+4; tgt = seq + (sign_extend(rd_or_offset) << 2).
  - 00 -> seq; 01 -> tgt; 10 -> alu_zero ? tgt : seq; 11 -> alu_zero ? seq : tgt.
  - All arithmetic is modulo 2^PC_WIDTH; wrap-around past the top or below 0 is silent.
- Unknown opcodes are not decoded here: the decoder drives bselect=00, so they advance sequentially.
- A pc whose low 2 bits are nonzero cannot occur from reset with RESET_PC word-aligned. The offset is shifted, so alignment is preserved.
- bselect and alu_zero are sampled only on the exec_done edge. The decoder's internal settling delay must be complete before exec_done, which is the datapath's responsibility.
- RESET_N asserted in the same cycle as imem_ready or exec_done: reset wins, nothing is captured.

Decomposition:
- Shared CPU package:
  - Opcode constants (LOADI=0 … MULT=9).
  - Branch-select encodings BSEL_SEQ/JUMP/BEQ/BNE.
  - Instruction field bit positions.
  - FSM state enum {FETCH, ISSUE}.
- One natural sub-module: next_pc_calc, purely combinational. Inputs pc, offset, bselect, alu_zero; output next_pc. It is reusable by a later pipelined fetch.

Test Plan:
- Reset/first fetch: release RESET_N with RESET_PC=0, imem_ready=1 immediately, rdata=32'h0200_0105 -> imem_req high in the first cycle, addr=0; next cycle instr_valid=1, opcode=8'h02, rd=8'h00, rs1=8'h01, rs2=8'h05.
- Memory wait states: imem_ready low for 3 cycles -> imem_req stays high with addr stable, instr_valid stays 0; capture occurs on the 4th cycle only.
- Sequential and jump: exec_done with bselect=00 at pc=8 -> next fetch addr=12. Then bselect=01, offset=8'hFE at pc=12 -> addr=12+4-8=8.
- Branches: bselect=10, zero=1, offset=3, pc=0x20 -> 0x30; bselect=10, zero=0 -> 0x24; bselect=11, zero=0, offset=3 -> 0x30; bselect=11, zero=1 -> 0x24.
- Wrap: pc=32'hFFFF_FFFC, bselect=00 -> addr=0. Also retired_count increments once per exec_done only, and exec_done pulses during FETCH are ignored.
- Mid-operation reset: assert RESET_N low during ISSUE and during FETCH wait -> immediately instr_valid=0, imem_req=0, pc=RESET_PC, retired_count=0; after release, fetch restarts at RESET_PC.
